// File: rtl/axi_sram_slave.sv
`timescale 1ns/1ps
// AXI4 responder fronting one single-port word SRAM; one transaction at a time,
// INCR/FIXED bursts of 1-16 beats (WRAP behaves as INCR), every beat is 4 bytes.
// Latency: AR handshake to first RVALID is 3 cycles, 3 cycles per later read beat;
// each accepted W beat is written to the SRAM in the same cycle.
// Backpressure: R outputs hold while RREADY is low, B holds until BREADY;
// ARREADY/AWREADY are low outside IDLE, and AW wins over AR in IDLE.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ar*_i / arready_o   read address channel
//   r*_o / rready_i     read data channel
//   aw*_i / awready_o   write address channel
//   w*_i / wready_o     write data channel
//   b*_o / bready_i     write response channel
//   mem_*_o, mem_rdata_i  SRAM macro port (read data valid the cycle after the access)
module axi_sram_slave #(
   parameter int ID_W   = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4,
   parameter int MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst,
   // read address
   input  logic [ID_W-1:0]   arid_i,
   input  logic [ADDR_W-1:0] araddr_i,
   input  logic [LEN_W-1:0]  arlen_i,
   input  logic [2:0]        arsize_i,
   input  logic [1:0]        arburst_i,
   input  logic              arvalid_i,
   output logic              arready_o,
   // read data
   output logic [ID_W-1:0]   rid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [1:0]        rresp_o,
   output logic              rlast_o,
   output logic              rvalid_o,
   input  logic              rready_i,
   // write address
   input  logic [ID_W-1:0]   awid_i,
   input  logic [ADDR_W-1:0] awaddr_i,
   input  logic [LEN_W-1:0]  awlen_i,
   input  logic [2:0]        awsize_i,
   input  logic [1:0]        awburst_i,
   input  logic              awvalid_i,
   output logic              awready_o,
   // write data
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [3:0]        wstrb_i,
   input  logic              wlast_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   // write response
   output logic [ID_W-1:0]   bid_o,
   output logic [1:0]        bresp_o,
   output logic              bvalid_o,
   input  logic              bready_i,
   // SRAM
   output logic              mem_cs_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_wstrb_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_CAP  = 3'd2,
      RD_DATA = 3'd3,
      WR_DATA = 3'd4,
      WR_RESP = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   state_t              state_q;
   logic                awready_q;
   logic                rvalid_q;
   logic                wready_q;
   logic                bvalid_q;
   logic [ID_W-1:0]     id_q;
   logic [MEM_AW-1:0]   addr_q;
   logic [MEM_AW-1:0]   addr_d;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    beat_q;
   logic [LEN_W-1:0]    beat_d;
   logic                fixed_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [1:0]          bresp_q;
   logic                last_beat;
   logic                w_hs;

   // Size, byte offset, upper address bits and the WRAP bit carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{arsize_i, awsize_i, arburst_i[1], awburst_i[1],
                            araddr_i[1:0], awaddr_i[1:0],
                            araddr_i[ADDR_W-1:MEM_AW+2], awaddr_i[ADDR_W-1:MEM_AW+2]};

   // Next beat address: FIXED stays put, INCR rolls over at the top of the SRAM.
   always_comb begin
      addr_d = fixed_q ? addr_q : addr_q + MEM_AW'(1);
      beat_d = beat_q + LEN_W'(1);
   end

   assign last_beat = (beat_q == len_q);
   assign w_hs      = wready_q & wvalid_i;

   // awready_q doubles as "in IDLE and out of reset for at least one edge", so
   // every READY output is low while reset is asserted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         awready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         fixed_q   <= 1'b0;
         rdata_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (state_q)
            IDLE: begin
               if (awready_q && awvalid_i) begin
                  id_q      <= awid_i;
                  addr_q    <= awaddr_i[MEM_AW+1:2];
                  len_q     <= awlen_i;
                  fixed_q   <= (awburst_i == BURST_FIXED);
                  beat_q    <= '0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  state_q   <= WR_DATA;
               end else if (awready_q && arvalid_i) begin
                  id_q      <= arid_i;
                  addr_q    <= araddr_i[MEM_AW+1:2];
                  len_q     <= arlen_i;
                  fixed_q   <= (arburst_i == BURST_FIXED);
                  beat_q    <= '0;
                  awready_q <= 1'b0;
                  state_q   <= RD_REQ;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            RD_REQ: begin
               state_q <= RD_CAP;
            end
            RD_CAP: begin
               rdata_q  <= mem_rdata_i;
               rvalid_q <= 1'b1;
               state_q  <= RD_DATA;
            end
            RD_DATA: begin
               if (rready_i) begin
                  rvalid_q <= 1'b0;
                  if (last_beat) begin
                     awready_q <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     beat_q  <= beat_d;
                     addr_q  <= addr_d;
                     state_q <= RD_REQ;
                  end
               end
            end
            WR_DATA: begin
               if (wvalid_i) begin
                  addr_q <= addr_d;
                  if (wlast_i || last_beat) begin
                     // OKAY only when WLAST and the final beat coincide.
                     bresp_q  <= (wlast_i && last_beat) ? RESP_OKAY : RESP_SLVERR;
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     state_q  <= WR_RESP;
                  end else begin
                     beat_q <= beat_d;
                  end
               end
            end
            WR_RESP: begin
               if (bready_i) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               awready_q <= 1'b0;
               rvalid_q  <= 1'b0;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign awready_o = awready_q;
   assign arready_o = awready_q & ~awvalid_i;

   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign rid_o     = id_q;
   assign rresp_o   = RESP_OKAY;
   assign rlast_o   = rvalid_q & last_beat;

   assign wready_o  = wready_q;

   assign bvalid_o  = bvalid_q;
   assign bid_o     = id_q;
   assign bresp_o   = bresp_q;

   // Reads are issued from RD_REQ; writes go straight through on the W handshake.
   assign mem_cs_o    = (state_q == RD_REQ) | w_hs;
   assign mem_we_o    = w_hs;
   assign mem_wstrb_o = w_hs ? wstrb_i : 4'b0000;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = w_hs ? wdata_i : '0;

endmodule

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
module tb_axi_sram_slave;
   localparam int ID_W = 8, ADDR_W = 32, DATA_W = 32, LEN_W = 4, MEM_AW = 14;
   localparam int MEM_WORDS = 1 << MEM_AW;
   localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01;

   logic clk = 1'b0;
   logic rst;
   logic [ID_W-1:0] arid, awid, rid, bid;
   logic [ADDR_W-1:0] araddr, awaddr;
   logic [LEN_W-1:0] arlen, awlen;
   logic [2:0] arsize, awsize;
   logic [1:0] arburst, awburst, rresp, bresp;
   logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
   logic [DATA_W-1:0] rdata, wdata, mem_wdata, mem_rdata;
   logic [3:0] wstrb, mem_wstrb;
   logic wlast, wvalid, wready, bvalid, bready, mem_cs, mem_we;
   logic [MEM_AW-1:0] mem_addr;

   int vectors = 0, miscompares = 0;
   int cyc = 0;

   axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_AW(MEM_AW)) dut (
      .clk(clk), .rst(rst),
      .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
      .arvalid_i(arvalid), .arready_o(arready),
      .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready),
      .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
      .awvalid_i(awvalid), .awready_o(awready),
      .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
      .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
      .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_wstrb_o(mem_wstrb), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM macro: byte-enabled write, registered read data.
   logic [31:0] sram [0:MEM_WORDS-1];
   always @(posedge clk) begin
      if (mem_cs && !mem_we) mem_rdata <= sram[mem_addr];
      if (mem_cs && mem_we)
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct { logic we; logic [13:0] addr; logic [3:0] strb; logic [31:0] data; } acc_t;
   typedef struct { logic [31:0] data; logic [7:0] id; logic last; } rbeat_t;
   typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
   acc_t   exp_acc[$];
   rbeat_t exp_r[$];
   bexp_t  exp_b[$];
   logic [31:0] ref_mem [0:MEM_WORDS-1];
   int next_r_cyc = 0;
   logic w_act = 1'b0, w_fixed;
   logic [7:0] w_id;
   int w_base, w_len, w_beat;
   logic rst_edge;

   // logs used by the directed literal checks
   logic [31:0] r_got[$];
   logic [7:0]  rid_log[$], bid_log[$];
   logic [1:0]  b_log[$];
   logic [13:0] acc_log[$];
   int wr_cnt = 0, aw_hs_cyc = 0, ar_hs_cyc = 0, b_hs_cyc = 0, r_first_cyc = 0;
   logic r_first_pend = 1'b0;

   always @(posedge clk or negedge rst)
      if (!rst) rst_edge <= 1'b0; else rst_edge <= 1'b1;

   logic idle_m, cs_m, w_hs;
   acc_t acc_tmp; rbeat_t r_tmp; bexp_t b_tmp;
   int a;

   always @(negedge clk) begin
      if (!rst) begin
         exp_acc.delete(); exp_r.delete(); exp_b.delete(); w_act = 1'b0;
      end else begin
         idle_m = rst_edge && !w_act && exp_b.size() == 0 && exp_r.size() == 0;
         chk("awready", awready, idle_m);
         chk("arready", arready, idle_m && !awvalid);
         chk("wready", wready, w_act);
         chk("rvalid", rvalid, exp_r.size() > 0 && cyc >= next_r_cyc);
         if (rvalid && r_first_pend) begin r_first_cyc = cyc; r_first_pend = 1'b0; end
         if (rvalid && exp_r.size() > 0) begin
            chk("rdata", rdata, exp_r[0].data);
            chk("rid", rid, exp_r[0].id);
            chk("rlast", rlast, exp_r[0].last);
            chk("rresp", rresp, 2'b00);
            if (rready) begin
               r_got.push_back(rdata); rid_log.push_back(rid);
               void'(exp_r.pop_front());
               next_r_cyc = cyc + 3;
            end
         end
         chk("bvalid", bvalid, exp_b.size() > 0);
         if (bvalid && exp_b.size() > 0) begin
            chk("bid", bid, exp_b[0].id);
            chk("bresp", bresp, exp_b[0].resp);
            if (bready) begin
               b_log.push_back(bresp); bid_log.push_back(bid); b_hs_cyc = cyc;
               void'(exp_b.pop_front());
            end
         end
         if (awvalid && awready) begin
            w_act = 1'b1; w_id = awid; w_base = int'(awaddr[15:2]); w_len = int'(awlen);
            w_fixed = (awburst == B_FIXED); w_beat = 0; aw_hs_cyc = cyc;
         end
         if (arvalid && arready) begin
            for (int k = 0; k <= int'(arlen); k++) begin
               a = (arburst == B_FIXED) ? int'(araddr[15:2]) : (int'(araddr[15:2]) + k) % MEM_WORDS;
               acc_tmp.we = 1'b0; acc_tmp.addr = 14'(a); acc_tmp.strb = 4'h0; acc_tmp.data = 32'h0;
               exp_acc.push_back(acc_tmp);
               r_tmp.data = ref_mem[a]; r_tmp.id = arid; r_tmp.last = (k == int'(arlen));
               exp_r.push_back(r_tmp);
            end
            next_r_cyc = cyc + 3; ar_hs_cyc = cyc; r_first_pend = 1'b1;
         end
         w_hs = wvalid && wready && w_act;
         if (w_hs) begin
            a = w_fixed ? w_base : (w_base + w_beat) % MEM_WORDS;
            acc_tmp.we = 1'b1; acc_tmp.addr = 14'(a); acc_tmp.strb = wstrb; acc_tmp.data = wdata;
            exp_acc.push_back(acc_tmp);
            for (int b = 0; b < 4; b++) if (wstrb[b]) ref_mem[a][8*b +: 8] = wdata[8*b +: 8];
            if (wlast || w_beat == w_len) begin
               b_tmp.id = w_id; b_tmp.resp = (wlast && w_beat == w_len) ? 2'b00 : 2'b10;
               exp_b.push_back(b_tmp); w_act = 1'b0;
            end else w_beat++;
         end
         cs_m = w_hs || (exp_acc.size() > 0 && !exp_acc[0].we && cyc == next_r_cyc - 2);
         chk("mem_cs", mem_cs, cs_m);
         if (mem_cs && exp_acc.size() > 0) begin
            chk("mem_we", mem_we, exp_acc[0].we);
            chk("mem_addr", mem_addr, exp_acc[0].addr);
            if (exp_acc[0].we) begin
               chk("mem_wstrb", mem_wstrb, exp_acc[0].strb);
               chk("mem_wdata", mem_wdata, exp_acc[0].data);
            end
            acc_log.push_back(mem_addr);
            if (mem_we) wr_cnt++;
            void'(exp_acc.pop_front());
         end else if (!mem_cs) begin
            chk("mem_we_idle", mem_we, 1'b0);
            chk("mem_wstrb_idle", mem_wstrb, 4'h0);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
      logic ok = 1'b0;
      arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin @(negedge clk); if (arready) begin ok = 1'b1; break; end end
      chk("ar_handshake", ok, 1'b1);
      @(posedge clk); #1 arvalid = 1'b0;
   endtask

   task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
      logic ok = 1'b0;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin @(negedge clk); if (awready) begin ok = 1'b1; break; end end
      chk("aw_handshake", ok, 1'b1);
      @(posedge clk); #1 awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
      logic ok = 1'b0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin @(negedge clk); if (wready) begin ok = 1'b1; break; end end
      chk("w_handshake", ok, 1'b1);
      @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic wait_b(input int n);
      for (int i = 0; i < 200; i++) begin @(negedge clk); if (b_log.size() >= n) break; end
      chk("b_complete", b_log.size() >= n, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic wait_r(input int n);
      for (int i = 0; i < 300; i++) begin @(negedge clk); if (r_got.size() >= n) break; end
      chk("r_complete", r_got.size() >= n, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input int nbeats, input int last_at,
                              input logic [3:0] s, input logic [31:0] d0, input int step);
      int target = b_log.size() + 1;
      send_aw(id, addr, len, burst);
      for (int i = 0; i < nbeats; i++) send_w(d0 + 32'(i * step), s, i == last_at);
      wait_b(target);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_arready"}, arready, 1'b0);  chk({tag, "_awready"}, awready, 1'b0);
      chk({tag, "_wready"}, wready, 1'b0);    chk({tag, "_rvalid"}, rvalid, 1'b0);
      chk({tag, "_bvalid"}, bvalid, 1'b0);    chk({tag, "_mem_cs"}, mem_cs, 1'b0);
      chk({tag, "_mem_we"}, mem_we, 1'b0);    chk({tag, "_mem_wstrb"}, mem_wstrb, 4'h0);
      chk({tag, "_rid"}, rid, 8'h0);          chk({tag, "_bid"}, bid, 8'h0);
      chk({tag, "_rdata"}, rdata, 32'h0);     chk({tag, "_rlast"}, rlast, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      rst = 1'b1;

      // single write then single read
      write_burst(8'h01, 32'h40, 4'd0, B_INCR, 1, 0, 4'hF, 32'hDEADBEEF, 0);
      chk("t1_bresp", b_log[b_log.size()-1], 2'b00);
      r_got.delete(); rid_log.delete();
      send_ar(8'h05, 32'h40, 4'd0, B_INCR);
      wait_r(1);
      chk("t1_rdata", r_got[0], 32'hDEADBEEF);
      chk("t1_rid", rid_log[0], 8'h05);
      chk("t1_latency", r_first_cyc - ar_hs_cyc, 3);

      // 4-beat INCR partial-strobe write over a preloaded region
      write_burst(8'h02, 32'h100, 4'd3, B_INCR, 4, 3, 4'hF, 32'hFFFFFFFF, 0);
      acc_log.delete();
      write_burst(8'h3C, 32'h100, 4'd3, B_INCR, 4, 3, 4'b0011, 32'hA5A51000, 1);
      for (int i = 0; i < 4; i++) chk("t2_mem_addr", acc_log[i], 14'(32'h40 + i));
      chk("t2_bid", bid_log[bid_log.size()-1], 8'h3C);
      chk("t2_bresp", b_log[b_log.size()-1], 2'b00);
      r_got.delete();
      send_ar(8'h07, 32'h100, 4'd3, B_INCR);
      wait_r(4);
      for (int i = 0; i < 4; i++) chk("t2_readback", r_got[i], 32'hFFFF1000 + 32'(i));

      // R backpressure
      r_got.delete(); acc_log.delete();
      rready = 1'b0;
      send_ar(8'h09, 32'h100, 4'd1, B_INCR);
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (rvalid) break; end
      repeat (5) @(negedge clk);
      chk("t3_hold_rdata", rdata, 32'hFFFF1000);
      chk("t3_hold_rlast", rlast, 1'b0);
      chk("t3_hold_accesses", acc_log.size(), 1);
      @(posedge clk); #1 rready = 1'b1;
      wait_r(2);
      chk("t3_beat0", r_got[0], 32'hFFFF1000);
      chk("t3_beat1", r_got[1], 32'hFFFF1001);
      chk("t3_accesses", acc_log.size(), 2);

      // simultaneous AR and AW
      r_got.delete();
      fork
         write_burst(8'h21, 32'h200, 4'd0, B_INCR, 1, 0, 4'hF, 32'h0BADF00D, 0);
         send_ar(8'h22, 32'h200, 4'd0, B_INCR);
      join
      wait_r(1);
      chk("t4_aw_first", aw_hs_cyc < ar_hs_cyc, 1'b1);
      chk("t4_ar_after_b", ar_hs_cyc, b_hs_cyc + 1);
      chk("t4_rdata", r_got[0], 32'h0BADF00D);

      // early WLAST, missing WLAST, FIXED burst
      b_log.delete(); wr_cnt = 0;
      write_burst(8'h31, 32'h300, 4'd3, B_INCR, 2, 1, 4'hF, 32'h50000000, 1);
      chk("t5_early_writes", wr_cnt, 2);
      chk("t5_early_bresp", b_log[0], 2'b10);
      write_burst(8'h32, 32'h340, 4'd1, B_INCR, 2, -1, 4'hF, 32'h60000000, 1);
      chk("t5_nolast_bresp", b_log[1], 2'b10);
      acc_log.delete();
      write_burst(8'h33, 32'h400, 4'd2, B_FIXED, 3, 2, 4'hF, 32'hC0DE0000, 1);
      for (int i = 0; i < 3; i++) chk("t5_fixed_addr", acc_log[i], 14'h100);
      chk("t5_fixed_bresp", b_log[2], 2'b00);
      r_got.delete();
      send_ar(8'h34, 32'h400, 4'd0, B_INCR);
      wait_r(1);
      chk("t5_fixed_data", r_got[0], 32'hC0DE0002);

      // INCR read wrapping at the top of the SRAM
      write_burst(8'h41, 32'h0000FFFC, 4'd0, B_INCR, 1, 0, 4'hF, 32'h11112222, 0);
      write_burst(8'h42, 32'h00000000, 4'd0, B_INCR, 1, 0, 4'hF, 32'h33334444, 0);
      acc_log.delete(); r_got.delete();
      send_ar(8'h43, 32'h0000FFFC, 4'd1, B_INCR);
      wait_r(2);
      chk("t6_addr0", acc_log[0], 14'h3FFF);
      chk("t6_addr1", acc_log[1], 14'h0000);
      chk("t6_data0", r_got[0], 32'h11112222);
      chk("t6_data1", r_got[1], 32'h33334444);

      // reset in the middle of a write burst
      send_aw(8'h51, 32'h600, 4'd3, B_INCR);
      send_w(32'hAAAA0000, 4'hF, 1'b0);
      send_w(32'hAAAA0001, 4'hF, 1'b0);
      wdata = 32'hAAAA0002; wstrb = 4'hF; wvalid = 1'b1;
      #1 rst = 1'b0;
      #1 check_zero("midrst");
      repeat (2) @(posedge clk);
      #1 check_zero("inrst");
      wvalid = 1'b0;
      rst = 1'b1;
      b_log.delete(); bid_log.delete();
      write_burst(8'h52, 32'h600, 4'd0, B_INCR, 1, 0, 4'hF, 32'h600DCAFE, 0);
      chk("t7_bid", bid_log[0], 8'h52);
      chk("t7_bresp", b_log[0], 2'b00);
      r_got.delete();
      send_ar(8'h53, 32'h600, 4'd0, B_INCR);
      wait_r(1);
      chk("t7_readback", r_got[0], 32'h600DCAFE);

      repeat (4) @(posedge clk);
      #1;
      chk("end_acc_empty", exp_acc.size(), 0);
      chk("end_r_empty", exp_r.size(), 0);
      chk("end_b_empty", exp_b.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
